// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: req/gnt/rvalid handshake with data memory,
// byte-lane steering for stores and alignment/extension for loads.
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] mem_r_data,
    output logic        busy,
    output logic        done,
    output logic        misaligned,
    output logic        err
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    localparam logic [9:0] LAST = 10'(TIMEOUT_CYCLES - 1);

    state_t      state, state_n;
    logic [9:0]  cnt;
    logic [2:0]  op_f3;
    logic [1:0]  op_off;
    logic        accept, legal_f3, illegal, mis, go;
    logic [3:0]  be_n;
    logic [31:0] wdata_n;
    logic        mis_n, err_n, load_ok, cnt_inc;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    // Decode of the op presented by execute
    always_comb begin
        accept = start & (is_load | is_store) & (state == IDLE || state == DONE);
        case (funct3)
            3'b000, 3'b001, 3'b010: legal_f3 = 1'b1;
            3'b100, 3'b101:         legal_f3 = is_load;
            default:                legal_f3 = 1'b0;
        endcase
        illegal = (is_load & is_store) | ~legal_f3;
        mis     = ((funct3[1:0] == 2'b01) & addr[0]) |
                  ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
        go      = accept & ~illegal & ~mis;
        case (funct3[1:0])
            2'b00: begin
                be_n    = 4'b0001 << addr[1:0];
                wdata_n = {4{store_data[7:0]}};
            end
            2'b01: begin
                be_n    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_n = {2{store_data[15:0]}};
            end
            default: begin
                be_n    = 4'b1111;
                wdata_n = store_data;
            end
        endcase
    end

    assign busy     = (state == REQ) || (state == WAIT) || go;
    assign dmem_req = (state == REQ);

    always_comb begin
        state_n = state;
        mis_n   = 1'b0;
        err_n   = 1'b0;
        load_ok = 1'b0;
        cnt_inc = 1'b0;
        case (state)
            IDLE, DONE: begin
                state_n = IDLE;
                if (accept) begin
                    if (illegal) begin
                        state_n = DONE;
                        err_n   = 1'b1;
                    end else if (mis) begin
                        state_n = DONE;
                        mis_n   = 1'b1;
                    end else begin
                        state_n = REQ;
                    end
                end
            end
            REQ: begin
                // A grant in the timeout cycle still completes the op
                if (dmem_gnt) begin
                    state_n = dmem_we ? DONE : WAIT;
                end else if (cnt == LAST) begin
                    state_n = DONE;
                    err_n   = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            WAIT: begin
                if (dmem_rvalid) begin
                    state_n = DONE;
                    load_ok = 1'b1;
                end else if (cnt == LAST) begin
                    state_n = DONE;
                    err_n   = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        case (op_off)
            2'd0:    ld_byte = dmem_rdata[7:0];
            2'd1:    ld_byte = dmem_rdata[15:8];
            2'd2:    ld_byte = dmem_rdata[23:16];
            default: ld_byte = dmem_rdata[31:24];
        endcase
        ld_half = op_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (op_f3)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'd0, ld_byte};
            3'b101:  ld_ext = {16'd0, ld_half};
            default: ld_ext = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            done       <= 1'b0;
            misaligned <= 1'b0;
            err        <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= '0;
            dmem_wdata <= '0;
            mem_r_data <= '0;
            op_f3      <= '0;
            op_off     <= '0;
            cnt        <= '0;
        end else begin
            state      <= state_n;
            done       <= (state_n == DONE);
            misaligned <= mis_n;
            err        <= err_n;
            if (go) begin
                dmem_we    <= is_store;
                dmem_addr  <= {addr[31:2], 2'b00};
                dmem_be    <= be_n;
                dmem_wdata <= wdata_n;
                op_f3      <= funct3;
                op_off     <= addr[1:0];
                cnt        <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt + 10'd1;
            end
            if (load_ok) mem_r_data <= ld_ext;
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit; each task drives one scenario and
// checks outputs against hand-computed values.
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, is_load = 1'b0, is_store = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] addr = '0, store_data = '0;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, mem_r_data;
    logic [3:0]  dmem_be;
    logic        dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        busy, done, misaligned, err;
    int tests = 0, fails = 0;

    mem_access_unit #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_load(is_load),
        .is_store(is_store), .funct3(funct3), .addr(addr),
        .store_data(store_data), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .mem_r_data(mem_r_data), .busy(busy), .done(done),
        .misaligned(misaligned), .err(err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic ld, input logic st, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] sd);
        start = 1'b1; is_load = ld; is_store = st; funct3 = f3; addr = a; store_data = sd;
    endtask

    task automatic idle_in();
        start = 1'b0; is_load = 1'b0; is_store = 1'b0;
    endtask

    // Runs a legal op with immediate grant; returns in the DONE cycle.
    task automatic exec(input logic ld, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input logic [31:0] rd);
        int n;
        present(ld, ~ld, f3, a, sd);
        step();
        idle_in();
        n = 0;
        while (!dmem_req && n < 10) begin step(); n++; end
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        if (ld) begin
            dmem_rvalid = 1'b1; dmem_rdata = rd;
            step();
            dmem_rvalid = 1'b0;
        end
    endtask

    task automatic test_reset();
        #3;
        tests++; if ({dmem_req, dmem_we, done, misaligned, err, busy} !== 6'b0) begin
            fails++; $display("FAIL reset_ctrl got %b exp 000000", {dmem_req, dmem_we, done, misaligned, err, busy}); end
        tests++; if ({dmem_addr, dmem_be, dmem_wdata, mem_r_data} !== '0) begin
            fails++; $display("FAIL reset_data got %h exp 0", {dmem_addr, dmem_be, dmem_wdata, mem_r_data}); end
        step(); rst_n = 1'b1; step();
    endtask

    task automatic test_lw();
        int busy_low = 0;
        present(1, 0, 3'b010, 32'h100, 0);
        #1;
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL lw_busy_accept got %b exp 1", busy); end
        step(); idle_in();
        tests++; if ({dmem_req, dmem_we, dmem_addr, dmem_be} !== {1'b1, 1'b0, 32'h100, 4'hF}) begin
            fails++; $display("FAIL lw_req got req=%b we=%b addr=%h be=%h exp 1 0 00000100 f", dmem_req, dmem_we, dmem_addr, dmem_be); end
        for (int i = 0; i < 2; i++) begin if (!busy || !dmem_req) busy_low++; step(); end
        dmem_gnt = 1'b1; if (!busy) busy_low++; step(); dmem_gnt = 1'b0;
        tests++; if ({dmem_req, busy} !== 2'b01) begin fails++; $display("FAIL lw_wait got req=%b busy=%b exp 0 1", dmem_req, busy); end
        dmem_rvalid = 1'b1; dmem_rdata = 32'hDEADBEEF; step(); dmem_rvalid = 1'b0;
        tests++; if (busy_low !== 0) begin fails++; $display("FAIL lw_busy_hold got %0d low cycles exp 0", busy_low); end
        tests++; if ({done, err, misaligned, busy} !== 4'b1000) begin fails++; $display("FAIL lw_done got %b exp 1000", {done, err, misaligned, busy}); end
        tests++; if (mem_r_data !== 32'hDEADBEEF) begin fails++; $display("FAIL lw_data got %h exp deadbeef", mem_r_data); end
        step();
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL lw_done_pulse got %b exp 0", done); end
    endtask

    task automatic test_load_ext();
        exec(1, 3'b000, 32'h103, 0, 32'h80FF1234);
        tests++; if (mem_r_data !== 32'hFFFFFF80) begin fails++; $display("FAIL lb got %h exp ffffff80", mem_r_data); end
        exec(1, 3'b100, 32'h103, 0, 32'h80FF1234);
        tests++; if (mem_r_data !== 32'h00000080) begin fails++; $display("FAIL lbu got %h exp 00000080", mem_r_data); end
        exec(1, 3'b001, 32'h102, 0, 32'h80FF1234);
        tests++; if (mem_r_data !== 32'hFFFF80FF) begin fails++; $display("FAIL lh got %h exp ffff80ff", mem_r_data); end
        exec(1, 3'b101, 32'h102, 0, 32'h80FF1234);
        tests++; if (mem_r_data !== 32'h000080FF) begin fails++; $display("FAIL lhu got %h exp 000080ff", mem_r_data); end
        exec(1, 3'b000, 32'h101, 0, 32'h80FF1234);
        tests++; if (mem_r_data !== 32'h00000012) begin fails++; $display("FAIL lb_off1 got %h exp 00000012", mem_r_data); end
        step();
    endtask

    task automatic test_store();
        present(0, 1, 3'b000, 32'h201, 32'h000000A5);
        step(); idle_in();
        tests++; if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata} !== {1'b1, 1'b1, 32'h200, 4'b0010, 32'hA5A5A5A5}) begin
            fails++; $display("FAIL sb_req got req=%b we=%b addr=%h be=%b wdata=%h", dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata); end
        step();
        tests++; if ({dmem_req, dmem_addr, dmem_be} !== {1'b1, 32'h200, 4'b0010}) begin
            fails++; $display("FAIL sb_hold got req=%b addr=%h be=%b", dmem_req, dmem_addr, dmem_be); end
        dmem_gnt = 1'b1; step(); dmem_gnt = 1'b0;
        tests++; if ({done, dmem_req, err} !== 3'b100) begin fails++; $display("FAIL sb_done got %b exp 100", {done, dmem_req, err}); end
        tests++; if (mem_r_data !== 32'h00000012) begin fails++; $display("FAIL sb_rdata_kept got %h exp 00000012", mem_r_data); end
        step();
        present(0, 1, 3'b001, 32'h202, 32'hFFFF1357);
        step(); idle_in();
        tests++; if ({dmem_be, dmem_wdata} !== {4'b1100, 32'h13571357}) begin
            fails++; $display("FAIL sh_lanes got be=%b wdata=%h exp 1100 13571357", dmem_be, dmem_wdata); end
        dmem_gnt = 1'b1; step(); dmem_gnt = 1'b0; step();
    endtask

    task automatic test_misaligned();
        int busy_hi = 0;
        present(1, 0, 3'b010, 32'h102, 0);
        #1; busy_hi += int'(busy);
        step(); idle_in(); busy_hi += int'(busy);
        tests++; if ({dmem_req, done, misaligned, err} !== 4'b0110) begin
            fails++; $display("FAIL lw_mis got req,done,mis,err=%b exp 0110", {dmem_req, done, misaligned, err}); end
        step();
        present(0, 1, 3'b001, 32'h301, 0);
        #1; busy_hi += int'(busy);
        step(); idle_in(); busy_hi += int'(busy);
        tests++; if ({dmem_req, done, misaligned, err} !== 4'b0110) begin
            fails++; $display("FAIL sh_mis got req,done,mis,err=%b exp 0110", {dmem_req, done, misaligned, err}); end
        tests++; if (busy_hi !== 0) begin fails++; $display("FAIL mis_busy got %0d exp 0", busy_hi); end
        step();
        tests++; if ({done, misaligned} !== 2'b00) begin fails++; $display("FAIL mis_clear got %b exp 00", {done, misaligned}); end
    endtask

    task automatic test_timeout();
        int n = 0;
        present(1, 0, 3'b010, 32'h500, 0);
        step(); idle_in();
        while (dmem_req && n < 20) begin n++; step(); end
        tests++; if (n !== 8) begin fails++; $display("FAIL to_req_cycles got %0d exp 8", n); end
        tests++; if ({done, err, misaligned, busy} !== 4'b1100) begin fails++; $display("FAIL to_err got %b exp 1100", {done, err, misaligned, busy}); end
        tests++; if (mem_r_data !== 32'h00000012) begin fails++; $display("FAIL to_rdata_kept got %h exp 00000012", mem_r_data); end
        step();
    endtask

    task automatic test_reset_mid();
        int seen_done = 0;
        present(1, 0, 3'b010, 32'h600, 0);
        step(); idle_in();
        dmem_gnt = 1'b1; step(); dmem_gnt = 1'b0;
        rst_n = 1'b0; #1;
        tests++; if ({dmem_req, done, err, misaligned, busy} !== 5'b0) begin
            fails++; $display("FAIL rst_mid_ctrl got %b exp 00000", {dmem_req, done, err, misaligned, busy}); end
        tests++; if ({dmem_addr, dmem_be, mem_r_data} !== '0) begin
            fails++; $display("FAIL rst_mid_data got addr=%h be=%h rdata=%h exp 0", dmem_addr, dmem_be, mem_r_data); end
        dmem_rvalid = 1'b1; step(); rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin step(); seen_done += int'(done); end
        dmem_rvalid = 1'b0;
        tests++; if (seen_done !== 0) begin fails++; $display("FAIL rst_mid_nodone got %0d exp 0", seen_done); end
    endtask

    task automatic test_back_to_back();
        present(0, 1, 3'b010, 32'h400, 32'h12345678);
        step(); idle_in();
        tests++; if ({dmem_we, dmem_be, dmem_wdata} !== {1'b1, 4'hF, 32'h12345678}) begin
            fails++; $display("FAIL sw_lanes got we=%b be=%h wdata=%h", dmem_we, dmem_be, dmem_wdata); end
        dmem_gnt = 1'b1; step(); dmem_gnt = 1'b0;
        present(1, 0, 3'b010, 32'h404, 0);
        #1;
        tests++; if ({done, busy} !== 2'b11) begin fails++; $display("FAIL b2b_accept got done,busy=%b exp 11", {done, busy}); end
        step(); idle_in();
        tests++; if ({dmem_req, dmem_we, dmem_addr} !== {1'b1, 1'b0, 32'h404}) begin
            fails++; $display("FAIL b2b_req got req=%b we=%b addr=%h exp 1 0 00000404", dmem_req, dmem_we, dmem_addr); end
        dmem_gnt = 1'b1; step(); dmem_gnt = 1'b0;
        dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFEF00D; step(); dmem_rvalid = 1'b0;
        tests++; if ({done, mem_r_data} !== {1'b1, 32'hCAFEF00D}) begin
            fails++; $display("FAIL b2b_load got done=%b data=%h exp 1 cafef00d", done, mem_r_data); end
        step();
    endtask

    task automatic test_illegal();
        int bad = 0;
        present(1, 1, 3'b010, 32'h700, 0);
        #1; bad += int'(busy);
        step(); idle_in(); bad += int'(dmem_req);
        tests++; if ({done, err, misaligned} !== 3'b110) begin fails++; $display("FAIL both_flags got %b exp 110", {done, err, misaligned}); end
        step();
        present(0, 1, 3'b100, 32'h700, 0);
        step(); idle_in(); bad += int'(dmem_req);
        tests++; if ({done, err} !== 2'b11) begin fails++; $display("FAIL bad_f3 got %b exp 11", {done, err}); end
        step();
        start = 1'b1; funct3 = 3'b010;
        #1; bad += int'(busy);
        step(); idle_in();
        tests++; if ({done, dmem_req} !== 2'b00) begin fails++; $display("FAIL no_flags got %b exp 00", {done, dmem_req}); end
        tests++; if (bad !== 0) begin fails++; $display("FAIL illegal_bus got %0d exp 0", bad); end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_load_ext();
        test_store();
        test_misaligned();
        test_timeout();
        test_back_to_back();
        test_illegal();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
